pong_renderer: RTL

Parametrised pixel renderer for the two-player Pong display. It takes the VGA timing position (`sx`, `sy`, `de`) and the game-object positions, then drives registered 12-bit RGB. It draws two paddles, the ball and a dashed centre net in per-object colours over a background that flashes for a programmable number of frames after a score event. It sits between the VGA timing generator and the pins, replacing the single-paddle white-only renderer.

---
 rtl/pong_renderer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pong_renderer.sv
// Pong pixel renderer: hit-tests paddles, ball and dashed net against the current
// scan position and drives registered RGB, with a post-score background flash.
module pong_renderer #(
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned NET_X        = 318,
    parameter int unsigned NET_W        = 4,
    parameter int unsigned NET_DASH     = 4,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PAD_W        = 10,
    parameter int unsigned PAD_H        = 40,
    parameter int unsigned PAD1_X       = 630,
    parameter int unsigned FLASH_FRAMES = 30,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter logic [11:0] FLASH_COLOR  = 12'hF00,
    parameter logic [11:0] NET_COLOR    = 12'h888,
    parameter logic [11:0] PAD_COLOR    = 12'hFFF,
    parameter logic [11:0] BALL_COLOR   = 12'hFF0
) (
    input  logic               clk_pxl,
    input  logic               reset,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic               de,
    input  logic [COORD_W-1:0] paddle0_pos_y,
    input  logic [COORD_W-1:0] paddle1_pos_y,
    input  logic [COORD_W-1:0] ball_pos_x,
    input  logic [COORD_W-1:0] ball_pos_y,
    input  logic               score_evt,
    output logic [3:0]         vga_red,
    output logic [3:0]         vga_green,
    output logic [3:0]         vga_blue,
    output logic               de_q,
    output logic               flash_active
);
    // One extra bit so pos + size never wraps.
    localparam int unsigned CW      = COORD_W + 1;
    localparam int unsigned FLASH_W = (FLASH_FRAMES == 0) ? 1 : $clog2(FLASH_FRAMES + 1);
    localparam int unsigned DASH_W  = (NET_DASH <= 1) ? 1 : $clog2(NET_DASH);

    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_FRAMES);
    localparam logic [DASH_W-1:0]  DASH_LAST  = DASH_W'(NET_DASH - 1);

    logic [CW-1:0] sx_w, sy_w, p0_w, p1_w, bx_w, by_w;
    logic          ball_hit, pad0_hit, pad1_hit, net_hit;
    logic          line_start, frame_tick;
    logic [11:0]   colour;

    logic [DASH_W-1:0]  dash_cnt;
    logic               dash_on;
    logic [FLASH_W-1:0] flash_cnt;

    assign sx_w = {1'b0, sx};
    assign sy_w = {1'b0, sy};
    assign p0_w = {1'b0, paddle0_pos_y};
    assign p1_w = {1'b0, paddle1_pos_y};
    assign bx_w = {1'b0, ball_pos_x};
    assign by_w = {1'b0, ball_pos_y};

    assign line_start = (sx == '0);
    assign frame_tick = (sx == '0) && (sy == '0);

    assign ball_hit = (sx_w >= bx_w) && (sx_w < bx_w + CW'(BALL_SIZE)) &&
                      (sy_w >= by_w) && (sy_w < by_w + CW'(BALL_SIZE));
    assign pad0_hit = (sx_w < CW'(PAD_W)) &&
                      (sy_w >= p0_w) && (sy_w < p0_w + CW'(PAD_H));
    assign pad1_hit = (sx_w >= CW'(PAD1_X)) && (sx_w < CW'(PAD1_X + PAD_W)) &&
                      (sy_w >= p1_w) && (sy_w < p1_w + CW'(PAD_H));
    assign net_hit  = dash_on && (sx_w >= CW'(NET_X)) && (sx_w < CW'(NET_X + NET_W));

    assign flash_active = (flash_cnt != '0);

    // Priority colour select: ball over paddles over net over background.
    always_comb begin
        colour = flash_active ? FLASH_COLOR : BG_COLOR;
        if (ball_hit) begin
            colour = BALL_COLOR;
        end else if (pad0_hit || pad1_hit) begin
            colour = PAD_COLOR;
        end else if (net_hit) begin
            colour = NET_COLOR;
        end
    end

    // Net dash state advances once per line, at sx==0, so it is stable over the net columns.
    always_ff @(posedge clk_pxl or posedge reset) begin
        if (reset) begin
            dash_cnt <= '0;
            dash_on  <= 1'b0;
        end else if (line_start) begin
            if (sy == '0) begin
                dash_cnt <= '0;
                dash_on  <= 1'b1;
            end else if (dash_cnt == DASH_LAST) begin
                dash_cnt <= '0;
                dash_on  <= ~dash_on;
            end else begin
                dash_cnt <= dash_cnt + 1'b1;
            end
        end
    end

    // Flash frame counter: a score (re)loads the full count and wins over a frame tick.
    always_ff @(posedge clk_pxl or posedge reset) begin
        if (reset) begin
            flash_cnt <= '0;
        end else if (score_evt) begin
            flash_cnt <= FLASH_LOAD;
        end else if (frame_tick && (flash_cnt != '0)) begin
            flash_cnt <= flash_cnt - 1'b1;
        end
    end

    // Output register: colour blanked outside the active area, de delayed to match.
    always_ff @(posedge clk_pxl or posedge reset) begin
        if (reset) begin
            de_q                          <= 1'b0;
            {vga_red, vga_green, vga_blue} <= 12'h000;
        end else begin
            de_q                          <= de;
            {vga_red, vga_green, vga_blue} <= de ? colour : 12'h000;
        end
    end

endmodule
